// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration stream loader.
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } loader_state_e;

  localparam logic [32:0] CFG_SYNC_WORD = 33'h0_A5C3_5A3C;

  // Position of each fabric block within the configuration image.
  localparam int unsigned IDX_SELECT = 0;
  localparam int unsigned IDX_LTA    = 1;
  localparam int unsigned IDX_SB_ABC = 2;
  localparam int unsigned IDX_SB_D   = 3;
  localparam int unsigned IDX_LT0    = 4;
  localparam int unsigned IDX_SB_E0  = 12;
  localparam int unsigned IDX_SB_E1  = 13;

endpackage

// File: rtl/cfg_shadow_rf.sv
// Shadow copy of every configuration word written to the fabric, with a
// registered readback port (1-cycle latency, out-of-range index reads 0).
module cfg_shadow_rf #(
  parameter int DATA_W    = 33,
  parameter int NUM_WORDS = 14,
  parameter int ADDR_W    = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data
);

  localparam logic [ADDR_W:0] NW = (ADDR_W+1)'(NUM_WORDS);

  logic [DATA_W-1:0] mem_q [NUM_WORDS];
  logic [DATA_W-1:0] mem_d [NUM_WORDS];
  logic [DATA_W-1:0] rb_data_q, rb_data_d;

  always_comb begin
    mem_d     = mem_q;
    rb_data_d = '0;
    if (we && ({1'b0, waddr} < NW)) mem_d[waddr] = wdata;
    if ({1'b0, rb_addr} < NW) rb_data_d = mem_q[rb_addr];
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
      rb_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rb_data_q <= rb_data_d;
    end
  end

  assign rb_data = rb_data_q;

endmodule

// File: rtl/cfg_stream_loader.sv
// Loads a sync/data/checksum word stream into the fabric configuration bus and
// enables the fabric only after a checksum-verified image. Optional readback
// shadow under CFG_STREAM_LOADER_READBACK_EN.
module cfg_stream_loader
  import cfg_pkg::*;
#(
  parameter int DATA_W    = 33,
  parameter int NUM_WORDS = 14,
  parameter int ADDR_W    = 4,
  parameter logic [DATA_W-1:0] SYNC_WORD = DATA_W'(CFG_SYNC_WORD)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
`ifdef CFG_STREAM_LOADER_READBACK_EN
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
`endif
  output logic              fabric_en,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              in_ready_q, in_ready_d;
  logic              cfg_we_q, cfg_we_d;
  logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [DATA_W-1:0] cfg_data_q, cfg_data_d;
  logic              xfer;
  logic              is_sync;

  assign xfer    = in_valid & in_ready_q;
  assign is_sync = (in_data == SYNC_WORD);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    csum_d     = csum_q;
    in_ready_d = 1'b1;
    cfg_we_d   = 1'b0;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (xfer && is_sync) begin
          state_d = ST_LOAD;
          count_d = '0;
          csum_d  = '0;
        end
      end
      ST_LOAD: begin
        // Sync word is ordinary payload here; only the count ends the image.
        if (xfer) begin
          cfg_we_d   = 1'b1;
          cfg_addr_d = count_q;
          cfg_data_d = in_data;
          csum_d     = csum_q ^ in_data;
          if (count_q == LAST_IDX) begin
            state_d = ST_CHECK;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (xfer) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // in_ready is a flop so it stays low for the whole reset and the first edge.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      csum_q     <= '0;
      in_ready_q <= 1'b0;
      cfg_we_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      in_ready_q <= in_ready_d;
      cfg_we_q   <= cfg_we_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign cfg_we    = cfg_we_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign fabric_en = (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);

`ifdef CFG_STREAM_LOADER_READBACK_EN
  cfg_shadow_rf #(
    .DATA_W    (DATA_W),
    .NUM_WORDS (NUM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_shadow (
    .clock   (clock),
    .clear   (clear),
    .we      (cfg_we_q),
    .waddr   (cfg_addr_q),
    .wdata   (cfg_data_q),
    .rb_addr (rb_addr),
    .rb_data (rb_data)
  );
`endif

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Scoreboard bench for cfg_stream_loader: expected configuration writes are
// queued at each accepted word and popped when cfg_we is observed.
module tb_cfg_stream_loader;

  localparam int DATA_W    = 33;
  localparam int NUM_WORDS = 14;
  localparam int ADDR_W    = 4;
  localparam logic [DATA_W-1:0] SYNC = 33'h0_A5C3_5A3C;

  typedef enum int { M_IDLE, M_LOAD, M_CHECK, M_DONE, M_ERR } mstate_e;

  logic              clock = 1'b0;
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              fabric_en;
  logic              done;
  logic              error;
`ifdef CFG_STREAM_LOADER_READBACK_EN
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  mstate_e mstate = M_IDLE;
  int      mcount = 0;
  logic [DATA_W-1:0] mcsum = '0;

  cfg_stream_loader dut (
    .clock     (clock),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
`ifdef CFG_STREAM_LOADER_READBACK_EN
    .rb_addr   (rb_addr),
    .rb_data   (rb_data),
`endif
    .fabric_en (fabric_en),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every cfg_we must match the oldest queued write.
  always @(negedge clock) begin
    if (clear && cfg_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {60'd0, cfg_addr}, 64'hFFFF);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("cfg_addr", 64'(cfg_addr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
        check("cfg_data", 64'(cfg_data), 64'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic model_step(input logic [DATA_W-1:0] w);
    case (mstate)
      M_IDLE, M_DONE, M_ERR: if (w == SYNC) begin
        mstate = M_LOAD; mcount = 0; mcsum = '0;
      end
      M_LOAD: begin
        exp_q.push_back({ADDR_W'(mcount), w});
        mcsum ^= w;
        if (mcount == NUM_WORDS - 1) mstate = M_CHECK;
        else mcount++;
      end
      M_CHECK: mstate = (w == mcsum) ? M_DONE : M_ERR;
      default: mstate = M_IDLE;
    endcase
  endtask

  task automatic xfer(input logic [DATA_W-1:0] w, input bit stall);
    int n;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clock); #1; n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    @(posedge clock);
    model_step(w);
    #1;
    in_valid = 1'b0;
    check("fabric_en", 64'(fabric_en), 64'(mstate == M_DONE));
    check("done",      64'(done),      64'(mstate == M_DONE));
    check("error",     64'(error),     64'(mstate == M_ERR));
  endtask

  task automatic send_image(input bit bad_csum, input bit stall, input int sync_pos);
    logic [DATA_W-1:0] w, cs;
    cs = '0;
    xfer(SYNC, stall);
    for (int i = 0; i < NUM_WORDS; i++) begin
      w = (i == sync_pos) ? SYNC : DATA_W'(i);
      cs ^= w;
      xfer(w, stall);
    end
    xfer(bad_csum ? (cs ^ 33'h1) : cs, stall);
  endtask

  initial begin
`ifdef CFG_STREAM_LOADER_READBACK_EN
    rb_addr = '0;
`endif
    clear    = 1'b0;
    in_valid = 1'b1;
    in_data  = DATA_W'($urandom);
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 64'(in_ready),  0);
    check("rst_cfg_we",   64'(cfg_we),    0);
    check("rst_cfg_addr", 64'(cfg_addr),  0);
    check("rst_cfg_data", 64'(cfg_data),  0);
    check("rst_fabric",   64'(fabric_en), 0);
    check("rst_done",     64'(done),      0);
    check("rst_error",    64'(error),     0);
    in_valid = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    check("post_rst_ready", 64'(in_ready), 1);
    check("post_rst_we",    64'(cfg_we),   0);

    // Junk before sync is swallowed.
    xfer(33'h1, 1'b0);
    xfer(33'h2, 1'b0);

    send_image(1'b0, 1'b0, -1);
    check("nominal_fabric_en", 64'(fabric_en), 1);

    // Reload from DONE: fabric must drop before any new write.
    xfer(SYNC, 1'b0);
    check("reload_fab_drop", 64'(fabric_en), 0);
    check("reload_no_we", 64'(cfg_we), 0);
    for (int i = 0; i < NUM_WORDS; i++) xfer(DATA_W'(i), 1'b1);
    xfer(33'h1, 1'b1);
    check("stall_reload_done", 64'(done), 1);

    send_image(1'b1, 1'b0, -1);
    check("bad_error", 64'(error), 1);
    check("bad_fabric", 64'(fabric_en), 0);
    xfer(SYNC, 1'b0);
    check("err_cleared", 64'(error), 0);
    for (int i = 0; i < NUM_WORDS; i++) xfer(DATA_W'(i), 1'b0);
    xfer(33'h1, 1'b0);
    check("recover_done", 64'(done), 1);

    // Partial image with sync as word 5, aborted by clear after word 7.
    xfer(SYNC, 1'b0);
    for (int i = 0; i <= 7; i++) xfer((i == 5) ? SYNC : DATA_W'(i), 1'b0);
    @(negedge clock);
`ifdef CFG_STREAM_LOADER_READBACK_EN
    rb_addr = 4'd5;
    @(posedge clock); #1;
    check("rb_addr5", 64'(rb_data), 64'(SYNC));
    rb_addr = 4'd15;
    @(posedge clock); #1;
    check("rb_addr15", 64'(rb_data), 0);
    @(negedge clock);
`endif
    #1 clear = 1'b0;
    #1;
    check("abort_fabric", 64'(fabric_en), 0);
    check("abort_we", 64'(cfg_we), 0);
    mstate = M_IDLE;
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    // After abort the loader is idle: ordinary words are not written.
    xfer(33'h3, 1'b0);
    xfer(33'h4, 1'b0);
    send_image(1'b0, 1'b1, -1);
    check("final_done", 64'(done), 1);

    repeat (3) @(posedge clock);
    #1;
    check("sb_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
